// File: rtl/mont_lift.sv
// Lifts a residue into the word-level Montgomery domain: C = a * 2^(W_SIZE*STAGES) mod q.
// Latency: W_SIZE*STAGES+1 edges from accept to out_valid; initiation interval W_SIZE*STAGES+2.
// Backpressure: result holds in DONE until out_ready; no new operand is taken until then.
module mont_lift #(
    parameter int DATA_SIZE = 32,
    parameter int W_SIZE    = 16,
    parameter int STAGES    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_SIZE-W_SIZE-1:0] qH,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_SIZE-1:0]        a,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_SIZE-1:0]        C
);

    localparam int N  = W_SIZE * STAGES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] q_q, q_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d;
    logic [DATA_SIZE-1:0] c_q, c_d;

    logic [DATA_SIZE-1:0] q_in;
    logic [DATA_SIZE:0]   dbl;
    logic [DATA_SIZE:0]   q_ext;
    logic [DATA_SIZE-1:0] acc_next;

    // acc < q keeps 2*acc below 2q, so one conditional subtract restores the range
    always_comb begin
        q_in     = {qH, {W_SIZE{1'b0}}} + DATA_SIZE'(1);
        dbl      = {acc_q, 1'b0};
        q_ext    = {1'b0, q_q};
        acc_next = (dbl >= q_ext) ? DATA_SIZE'(dbl - q_ext) : DATA_SIZE'(dbl);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        acc_d   = acc_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_d     = q_in;
                    acc_d   = (a >= q_in) ? (a - q_in) : a;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    c_d     = acc_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign C         = c_q;

endmodule

// File: tb/tb_mont_lift.sv
// Bench for mont_lift: a transaction-level timing/value model checked every cycle, plus literal results.
module tb_mont_lift;

    localparam int N = 32;

    logic        clk;
    logic        reset;
    logic [15:0] qH;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] C;

    int          n_cmp;
    int          n_bad;
    logic [31:0] last_out;
    int          hs_cnt;

    mont_lift #(.DATA_SIZE(32), .W_SIZE(16), .STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .qH       (qH),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .C        (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a * 2^N mod q with wide plain arithmetic (valid for a < 2q)
    function automatic logic [31:0] ref_lift(input logic [31:0] av, input logic [15:0] qh);
        logic [127:0] qv;
        logic [127:0] pw;
        logic [127:0] av_w;
        qv   = {96'd0, qh, 16'd0} + 128'd1;
        pw   = (128'd1 << N) % qv;
        av_w = {96'd0, av};
        return 32'(((av_w % qv) * pw) % qv);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Per-cycle model: busy from accept until handshake, result ready N edges after accept
    initial begin : model_cmp
        bit          m_busy;
        int          m_k;
        logic [31:0] m_pend;
        logic [31:0] m_c;
        m_busy = 0;
        m_k    = 0;
        m_pend = '0;
        m_c    = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && m_k == N)});
            chk("C", C, m_c);
            if (out_valid && out_ready) begin
                last_out = C;
                hs_cnt++;
            end
            if (!reset) begin
                m_busy = 0;
                m_k    = 0;
                m_c    = '0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1;
                    m_k    = 0;
                    m_pend = ref_lift(a, qH);
                end
            end else if (m_k < N) begin
                m_k++;
                if (m_k == N) m_c = m_pend;
            end else if (out_ready) begin
                m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that accepts the operand
    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) note_timeout("accept");
        tick();
    endtask

    // Counts edges after the accept edge until out_valid is seen; returns at that negedge
    task automatic wait_valid(output int lat);
        bit ok;
        ok  = 0;
        lat = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1;
                break;
            end
            lat++;
        end
        if (!ok) note_timeout("out_valid");
    endtask

    task automatic handshake(input string nm, input logic [31:0] exp);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_result"}, last_out, exp);
        chk({nm, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_post_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [31:0] av, input logic [15:0] qh,
                          input int stall, input logic [31:0] exp);
        int lat;
        a         = av;
        qH        = qh;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        wait_accept();
        in_valid = 1'b0;
        a        = $urandom;
        qH       = 16'($urandom);
        wait_valid(lat);
        chk({nm, "_latency"}, 32'(lat), 32'(N));
        for (int s = 0; s < stall; s++) tick();
        if (stall > 0) begin
            @(negedge clk);
            chk({nm, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
            chk({nm, "_stall_C"}, C, exp);
        end
        handshake(nm, exp);
    endtask

    initial begin : stim
        int          lat;
        int          hs_before;
        logic [31:0] qv;
        logic [63:0] lim;
        logic [31:0] av;
        logic [15:0] qh;
        n_cmp     = 0;
        n_bad     = 0;
        hs_cnt    = 0;
        last_out  = '0;
        reset     = 1'b0;
        in_valid  = 1'b1;
        a         = 32'd1;
        qH        = 16'd3;
        out_ready = 1'b0;

        repeat (3) tick();
        chk("reset_C", C, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        chk("reset_no_accept", {31'd0, in_ready}, 32'd1);

        run_op("a1", 32'd1, 16'd3, 0, 32'd43691);
        run_op("a2", 32'd2, 16'd3, 0, 32'd87382);
        run_op("a0", 32'd0, 16'd3, 0, 32'd0);
        run_op("qm1", 32'd196608, 16'd3, 0, 32'd152918);
        run_op("q", 32'd196609, 16'd3, 0, 32'd0);
        run_op("qp1", 32'd196610, 16'd3, 0, 32'd43691);
        run_op("bp", 32'd1, 16'd3, 10, 32'd43691);

        // Operand changes during RUN with in_valid held high
        a        = 32'd1;
        qH       = 16'd3;
        in_valid = 1'b1;
        wait_accept();
        tick();
        a  = 32'd5;
        qH = 16'd7;
        wait_valid(lat);
        chk("stab1_latency", 32'(lat), 32'(N - 1));
        handshake("stab1", 32'd43691);
        wait_accept();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("stab2_latency", 32'(lat), 32'(N));
        handshake("stab2", 32'd149797);

        // Reset in the middle of RUN discards the operand
        hs_before = hs_cnt;
        a         = 32'd1;
        qH        = 16'd3;
        in_valid  = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_C", C, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (40) tick();
        out_ready = 1'b0;
        chk("midrst_no_result", 32'(hs_cnt), 32'(hs_before));
        run_op("midrst_a2", 32'd2, 16'd3, 0, 32'd87382);

        for (int i = 0; i < 25; i++) begin
            qh  = 16'($urandom);
            qv  = {qh, 16'd0} + 32'd1;
            lim = {31'd0, qv, 1'b0};
            if (lim > 64'h1_0000_0000) lim = 64'h1_0000_0000;
            av  = 32'({$urandom, $urandom} % lim);
            repeat ($urandom_range(0, 2)) tick();
            run_op("rand", av, qh, $urandom_range(0, 3), ref_lift(av, qh));
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
